// File: rtl/sid_bus_read_pkg.sv
// SID read path shared definitions: register addresses and bus FSM encoding.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
//
// Contents:
//   SID_POTX..SID_ENV3  live voice/paddle register addresses (5'h19..5'h1C)
//   bus_state_t         host-bus read FSM states (IDLE / DRIVE / HOLD)
//   is_voice_reg()      true for addresses that return live voice data
package sid_bus_read_pkg;

  localparam logic [4:0] SID_POTX = 5'h19;
  localparam logic [4:0] SID_POTY = 5'h1A;
  localparam logic [4:0] SID_OSC3 = 5'h1B;
  localparam logic [4:0] SID_ENV3 = 5'h1C;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2
  } bus_state_t;

  // The four live registers are contiguous, so a range compare covers them.
  function automatic logic is_voice_reg(input logic [4:0] a);
    return (a >= SID_POTX) && (a <= SID_ENV3);
  endfunction

endpackage

// File: rtl/sid_bus_read_sync.sv
// Async input synchroniser with edge detect: level, rise and fall strobes.
// Latency: level after SYNC_STAGES edges; rise/fall valid in the following cycle.
// Backpressure: none; free-running sampler.
//
// Ports:
//   i_clk     in   1  sampling clock
//   i_rst_n   in   1  synchronous reset, active low (clears all flops to 0)
//   i_async   in   1  asynchronous input pin
//   o_level   out  1  synchronised level (last synchroniser stage)
//   o_rise    out  1  one-cycle strobe, level went 0->1
//   o_fall    out  1  one-cycle strobe, level went 1->0
module sid_bus_read_sync #(
  parameter int SYNC_STAGES = 2  // must be >= 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;   // extra flop used only for edge detection

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  =  r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule

// File: rtl/sid_bus_read.sv
// SID read path: drives register data onto the host bus during a SID read cycle.
// Latency: data_oe/rdata valid SYNC_STAGES+1 cycles after phi2 rises at the pin.
// Backpressure: none; host bus timing is fixed, the unit only follows it.
//
// Ports:
//   i_sys_clk  in   1  master clock
//   i_rst_n    in   1  synchronous reset, active low
//   i_clken    in   1  1 MHz SID enable pulse, advances the latch decay
//   i_phi2     in   1  host phi2 (async)
//   i_cs_n     in   1  host chip select, active low (async)
//   i_rw       in   1  host r/w, 1 = read (async)
//   i_addr     in   5  register address (already synchronised)
//   i_wr       in   1  one-cycle write strobe from the write path
//   i_wdata    in   8  write data accompanying i_wr
//   i_pot_x    in   8  POTX value
//   i_pot_y    in   8  POTY value
//   i_osc3     in   8  voice-3 oscillator MSBs
//   i_env3     in   8  voice-3 envelope
//   o_rdata    out  8  data for the host bus (retained between cycles)
//   o_data_oe  out  1  host data pin output enable, 1 = drive
module sid_bus_read
  import sid_bus_read_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 3,
  parameter int DECAY_TICKS = 2000
) (
  input  logic       i_sys_clk,
  input  logic       i_rst_n,
  input  logic       i_clken,
  input  logic       i_phi2,
  input  logic       i_cs_n,
  input  logic       i_rw,
  input  logic [4:0] i_addr,
  input  logic       i_wr,
  input  logic [7:0] i_wdata,
  input  logic [7:0] i_pot_x,
  input  logic [7:0] i_pot_y,
  input  logic [7:0] i_osc3,
  input  logic [7:0] i_env3,
  output logic [7:0] o_rdata,
  output logic       o_data_oe
);

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int DCW = $clog2(DECAY_TICKS + 1);
  localparam int SCW = $clog2(SYNC_STAGES + 2);

  // ---------------------------------------------------------------------------
  // Host bus synchronisers
  // ---------------------------------------------------------------------------
  logic w_phi2_lvl, w_phi2_rise, w_phi2_fall;
  logic w_cs_n_lvl, w_cs_n_rise, w_cs_n_fall;
  logic w_rw_lvl,   w_rw_rise,   w_rw_fall;

  sid_bus_read_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_phi2 (
    .i_clk   (i_sys_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_phi2),
    .o_level (w_phi2_lvl),
    .o_rise  (w_phi2_rise),
    .o_fall  (w_phi2_fall)
  );

  sid_bus_read_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs_n (
    .i_clk   (i_sys_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_cs_n),
    .o_level (w_cs_n_lvl),
    .o_rise  (w_cs_n_rise),
    .o_fall  (w_cs_n_fall)
  );

  sid_bus_read_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rw (
    .i_clk   (i_sys_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_rw),
    .o_level (w_rw_lvl),
    .o_rise  (w_rw_rise),
    .o_fall  (w_rw_fall)
  );

  // Only the levels of cs_n and rw matter; their edge strobes are spare.
  logic w_unused;
  assign w_unused = ^{w_cs_n_rise, w_cs_n_fall, w_rw_rise, w_rw_fall};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  bus_state_t       r_state;
  logic [7:0]       r_rdata;
  logic             r_data_oe;
  logic [4:0]       r_addr;
  logic [HCW-1:0]   r_hold_cnt;
  logic             r_armed;
  logic [SCW-1:0]   r_settle;
  logic [7:0]       r_bus_latch;
  logic [DCW-1:0]   r_decay_cnt;

  logic [7:0]       w_mux_dat;
  logic             w_settled;
  logic             w_rd_done;

  // ---------------------------------------------------------------------------
  // Read data mux (sampled only when a read cycle starts)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_mux_dat = r_bus_latch;
    case (i_addr)
      SID_POTX: w_mux_dat = i_pot_x;
      SID_POTY: w_mux_dat = i_pot_y;
      SID_OSC3: w_mux_dat = i_osc3;
      SID_ENV3: w_mux_dat = i_env3;
      default:  w_mux_dat = r_bus_latch;
    endcase
  end

  // The synchronisers come out of reset at 0; if phi2 is already high at the
  // pin, the refill would look like a fresh rise. Arming waits until the
  // chain has refilled so a cycle caught mid-way through reset is not driven.
  assign w_settled = (r_settle == SCW'(SYNC_STAGES + 1));

  // A read of a live register completes when phi2 falls while driving.
  assign w_rd_done = (r_state == ST_DRIVE) && w_phi2_fall && is_voice_reg(r_addr);

  // ---------------------------------------------------------------------------
  // Bus read FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_rdata    <= 8'h00;
      r_data_oe  <= 1'b0;
      r_addr     <= 5'h00;
      r_hold_cnt <= '0;
      r_armed    <= 1'b0;
      r_settle   <= '0;
    end else begin
      if (!w_settled) begin
        r_settle <= r_settle + SCW'(1);
      end

      case (r_state)
        ST_IDLE: begin
          // A new cycle is only accepted once phi2 has been seen low here.
          if (!w_phi2_lvl && w_settled) begin
            r_armed <= 1'b1;
          end
          if (r_armed && w_phi2_rise && !w_cs_n_lvl && w_rw_lvl) begin
            r_state   <= ST_DRIVE;
            r_addr    <= i_addr;
            r_rdata   <= w_mux_dat;
            r_data_oe <= 1'b1;
          end
        end

        ST_DRIVE: begin
          // rdata is frozen here; a fall takes priority over a late deselect
          // so a read that reached its end is treated as completed.
          if (w_phi2_fall) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= HCW'(HOLD_CYCLES - 1);
          end else if (w_cs_n_lvl || !w_rw_lvl) begin
            r_state   <= ST_IDLE;
            r_data_oe <= 1'b0;
          end
        end

        ST_HOLD: begin
          if (w_phi2_rise) begin
            // Cycle started too early: release the bus and skip it entirely.
            r_state   <= ST_IDLE;
            r_data_oe <= 1'b0;
            r_armed   <= 1'b0;
          end else if (r_hold_cnt == '0) begin
            r_state   <= ST_IDLE;
            r_data_oe <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt - HCW'(1);
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_data_oe <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Decaying bus latch
  // ---------------------------------------------------------------------------
  // Any reload takes priority over a clken decrement in the same cycle; a
  // write takes priority over a simultaneous read completion.
  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      r_bus_latch <= 8'h00;
      r_decay_cnt <= '0;
    end else if (i_wr) begin
      r_bus_latch <= i_wdata;
      r_decay_cnt <= DCW'(DECAY_TICKS);
    end else if (w_rd_done) begin
      r_bus_latch <= r_rdata;
      r_decay_cnt <= DCW'(DECAY_TICKS);
    end else if (i_clken && (r_decay_cnt != '0)) begin
      r_decay_cnt <= r_decay_cnt - DCW'(1);
      if (r_decay_cnt == DCW'(1)) begin
        r_bus_latch <= 8'h00;
      end
    end
  end

  assign o_rdata   = r_rdata;
  assign o_data_oe = r_data_oe;

endmodule

// File: tb/tb_sid_bus_read.sv
// Randomized self-checking bench for sid_bus_read against a transaction-level model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_sid_bus_read;

  localparam int SYNC  = 2;
  localparam int HOLD  = 3;
  localparam int DECAY = 2000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clken = 1'b0;
  logic       phi2 = 1'b0;
  logic       cs_n = 1'b1;
  logic       rw = 1'b1;
  logic [4:0] addr = 5'h00;
  logic       wr = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] pot_x = 8'h00;
  logic [7:0] pot_y = 8'h00;
  logic [7:0] osc3 = 8'h00;
  logic [7:0] env3 = 8'h00;
  logic [7:0] rdata;
  logic       data_oe;

  always #5 clk = ~clk;

  sid_bus_read #(
    .SYNC_STAGES (SYNC),
    .HOLD_CYCLES (HOLD),
    .DECAY_TICKS (DECAY)
  ) dut (
    .i_sys_clk (clk),
    .i_rst_n   (rst_n),
    .i_clken   (clken),
    .i_phi2    (phi2),
    .i_cs_n    (cs_n),
    .i_rw      (rw),
    .i_addr    (addr),
    .i_wr      (wr),
    .i_wdata   (wdata),
    .i_pot_x   (pot_x),
    .i_pot_y   (pot_y),
    .i_osc3    (osc3),
    .i_env3    (env3),
    .o_rdata   (rdata),
    .o_data_oe (data_oe)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] last_rd = 8'h00;

  // Reference model: bus latch contents and clken ticks left before it clears.
  logic [7:0] m_latch = 8'h00;
  int         m_ticks = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_is_voice(input logic [4:0] a);
    return (a >= 5'h19) && (a <= 5'h1C);
  endfunction

  function automatic logic [7:0] model_mux(input logic [4:0] a);
    case (a)
      5'h19:   return pot_x;
      5'h1A:   return pot_y;
      5'h1B:   return osc3;
      5'h1C:   return env3;
      default: return m_latch;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_pots();
    pot_x = 8'($urandom);
    pot_y = 8'($urandom);
    osc3  = 8'($urandom);
    env3  = 8'($urandom);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    m_latch = d;
    m_ticks = DECAY;
  endtask

  // n clken pulses; each pulse may carry a simultaneous write (wr_pct %).
  task automatic ticks(input int n, input int wr_pct);
    for (int i = 0; i < n; i++) begin
      bit do_wr;
      logic [7:0] d;
      @(negedge clk);
      do_wr = ($urandom_range(0, 99) < wr_pct);
      d = 8'($urandom);
      clken = 1'b1;
      if (do_wr) begin wr = 1'b1; wdata = d; end
      @(negedge clk);
      clken = 1'b0; wr = 1'b0;
      if (do_wr) begin
        m_latch = d; m_ticks = DECAY;
      end else if (m_ticks > 0) begin
        m_ticks--;
        if (m_ticks == 0) m_latch = 8'h00;
      end
    end
  endtask

  // One host bus cycle. Inputs change mid-DRIVE to confirm rdata is frozen.
  task automatic bus_cycle(input logic [4:0] a, input logic csn, input logic rwv, input bit abort);
    logic [7:0] exp_dat;
    bit is_rd, do_abort, oe_any, oe_fall_any;
    int hi, rise_at, drop_at, fall_at;
    is_rd    = !csn && rwv;
    do_abort = abort && is_rd;
    hi       = do_abort ? 9 : 6 + int'($urandom_range(0, 3));
    exp_dat  = model_mux(a);
    rise_at = -1; drop_at = -1; fall_at = -1; oe_any = 0; oe_fall_any = 0;
    @(negedge clk);
    addr = a; cs_n = csn; rw = rwv; phi2 = 1'b1;
    for (int k = 1; k <= hi; k++) begin
      @(posedge clk); #1;
      if (data_oe) oe_any = 1;
      if (data_oe && rise_at < 0) rise_at = k;
      if (!data_oe && rise_at >= 0 && drop_at < 0) drop_at = k;
      if (k == SYNC + 2) begin
        pot_x = ~pot_x; pot_y = ~pot_y; env3 = ~env3;
        osc3  = (osc3 == 8'hA5) ? 8'h11 : ~osc3;
        addr  = ~a;
        if (do_abort) cs_n = 1'b1;
      end
    end
    if (is_rd) begin
      check_eq("oe_rise_latency", rise_at, SYNC + 1);
      check_eq("rdata", int'(rdata), int'(exp_dat));
      last_rd = rdata;
    end else begin
      check_eq("no_drive_high", int'(oe_any), 0);
    end
    if (do_abort) check_eq("deselect_drop_latency", drop_at, 2 * SYNC + 3);
    @(negedge clk);
    phi2 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (data_oe) oe_fall_any = 1;
      if (!data_oe && fall_at < 0) fall_at = k;
    end
    if (is_rd && !do_abort) check_eq("oe_fall_latency", fall_at, SYNC + 1 + HOLD);
    else                    check_eq("no_drive_low", int'(oe_fall_any), 0);
    cs_n = 1'b1; rw = 1'b1;
    idle(3);
    if (is_rd && !do_abort && model_is_voice(a)) begin
      m_latch = exp_dat;
      m_ticks = DECAY;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int drop_at;
    bit oe_late;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_oe", int'(data_oe), 0);
    check_eq("reset_rdata", int'(rdata), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);

    // Live register read
    rand_pots();
    osc3 = 8'hA5;
    bus_cycle(5'h1B, 1'b0, 1'b1, 1'b0);
    check_eq("osc3_read", int'(last_rd), 8'hA5);

    // Write then latch read, then decay boundary
    write_reg(5'h04, 8'h3C);
    bus_cycle(5'h00, 1'b0, 1'b1, 1'b0);
    check_eq("latch_after_write", int'(last_rd), 8'h3C);
    ticks(DECAY - 1, 0);
    bus_cycle(5'h00, 1'b0, 1'b1, 1'b0);
    check_eq("latch_one_tick_left", int'(last_rd), 8'h3C);
    ticks(1, 0);
    bus_cycle(5'h00, 1'b0, 1'b1, 1'b0);
    check_eq("latch_decayed", int'(last_rd), 8'h00);

    // Write cycle and deselected read never drive
    bus_cycle(5'h1B, 1'b0, 1'b0, 1'b0);
    bus_cycle(5'h1B, 1'b1, 1'b1, 1'b0);

    // Deselect while phi2 high
    bus_cycle(5'h1A, 1'b0, 1'b1, 1'b1);

    // phi2 rises again during HOLD: bus released, second cycle not serviced
    osc3 = 8'h5A;
    @(negedge clk);
    addr = 5'h1B; cs_n = 1'b0; rw = 1'b1; phi2 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_eq("hold_abort_rdata", int'(rdata), 8'h5A);
    @(negedge clk);
    phi2 = 1'b0;
    drop_at = -1; oe_late = 0;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      if (!data_oe && drop_at < 0) drop_at = k;
      if (drop_at >= 0 && data_oe) oe_late = 1;
      if (k == 1) begin @(negedge clk); phi2 = 1'b1; end
    end
    check_eq("hold_abort_drop", drop_at, SYNC + 2);
    check_eq("hold_abort_no_redrive", int'(oe_late), 0);
    @(negedge clk);
    phi2 = 1'b0; cs_n = 1'b1;
    idle(6);
    m_latch = 8'h5A; m_ticks = DECAY;
    bus_cycle(5'h00, 1'b0, 1'b1, 1'b0);
    check_eq("latch_from_voice_read", int'(last_rd), 8'h5A);

    // Randomized traffic
    for (int it = 0; it < 50; it++) begin
      int op, kind;
      logic [4:0] a;
      op = int'($urandom_range(0, 9));
      if (op <= 2) begin
        write_reg(5'($urandom), 8'($urandom));
      end else if (op <= 7) begin
        rand_pots();
        a = ($urandom_range(0, 1) == 0) ? 5'(25 + $urandom_range(0, 3)) : 5'($urandom);
        kind = int'($urandom_range(0, 9));
        if (kind < 7)       bus_cycle(a, 1'b0, 1'b1, $urandom_range(0, 7) == 0);
        else if (kind == 7) bus_cycle(a, 1'b1, 1'b1, 1'b0);
        else if (kind == 8) bus_cycle(a, 1'b0, 1'b0, 1'b0);
        else                bus_cycle(a, 1'b1, 1'b0, 1'b0);
      end else begin
        ticks(int'($urandom_range(0, 300)), 10);
      end
    end

    // Reset during DRIVE
    write_reg(5'h02, 8'h7E);
    pot_y = 8'h33;
    @(negedge clk);
    addr = 5'h1A; cs_n = 1'b0; rw = 1'b1; phi2 = 1'b1;
    repeat (SYNC + 2) @(posedge clk);
    #1;
    check_eq("pre_reset_oe", int'(data_oe), 1);
    @(negedge clk);
    rst_n = 1'b0; phi2 = 1'b0; cs_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_reset_oe", int'(data_oe), 0);
    check_eq("mid_reset_rdata", int'(rdata), 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_latch = 8'h00; m_ticks = 0;
    idle(8);
    bus_cycle(5'h00, 1'b0, 1'b1, 1'b0);
    check_eq("latch_after_reset", int'(last_rd), 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
